// File: rtl/mig_tt_scanner.sv
`default_nettype none
// ============================================================================
// mig_tt_scanner : programmable 3-input majority-node chain with a
//                  truth-table scan engine streaming packed words.
// Revision       : 1.0
// ============================================================================
module mig_tt_scanner #(
   parameter int N_IN    = 7,
   parameter int N_NODES = 6,
   parameter int TT_W    = 32,
   parameter int SEL_W   = $clog2(1 + N_IN + N_NODES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [$clog2(N_NODES)-1:0] cfg_addr,
   input  logic [3*(SEL_W+1)-1:0]     cfg_data,
   input  logic                       out_inv,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       tt_valid,
   input  logic                       tt_ready,
   output logic [TT_W-1:0]            tt_data,
   output logic                       tt_last,
   output logic [N_IN:0]              onset_count
);

   localparam int OP_W      = SEL_W + 1;
   localparam int CFG_W     = 3 * OP_W;
   localparam int SRC_W     = 2 ** SEL_W;
   localparam int NODE_BASE = 1 + N_IN;
   localparam int WB_W      = $clog2(TT_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [N_NODES*CFG_W-1:0]   cfg_q, cfg_d;
   logic [N_IN:0]              ctr_q, ctr_d;
   logic [TT_W-1:0]            word_q, word_d;
   logic [N_IN:0]              onset_q, onset_d;
   logic                       inv_q, inv_d;
   logic                       f_w;

   // Source vector is padded to 2^SEL_W so any operand index selects in range;
   // indices not yet produced (forward refs, out of range) read as 0.
   function automatic logic eval_net(input logic [N_IN-1:0]          x,
                                     input logic [N_NODES*CFG_W-1:0] cfg);
      logic [SRC_W-1:0] src;
      logic [OP_W-1:0]  op;
      logic [2:0]       v;
      src         = '0;
      src[N_IN:1] = x;
      v           = '0;
      for (int k = 0; k < N_NODES; k++) begin
         for (int o = 0; o < 3; o++) begin
            op = cfg[k*CFG_W + o*OP_W +: OP_W];
            v[o +: 1] = op[SEL_W] ^
                        ((int'(op[SEL_W-1:0]) < NODE_BASE + k) ? src[op[SEL_W-1:0]] : 1'b0);
         end
         src[NODE_BASE + k +: 1] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
      end
      return src[NODE_BASE + N_NODES - 1];
   endfunction

   assign busy        = (state_q == ST_EVAL) || (state_q == ST_HOLD);
   assign done        = (state_q == ST_DONE);
   assign tt_valid    = (state_q == ST_HOLD);
   assign tt_data     = word_q;
   assign tt_last     = (state_q == ST_HOLD) && ctr_q[N_IN];
   assign onset_count = onset_q;

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      ctr_d   = ctr_q;
      word_d  = word_q;
      onset_d = onset_q;
      inv_d   = inv_q;
      f_w     = eval_net(ctr_q[N_IN-1:0], cfg_q) ^ inv_q;

      if (cfg_we && !busy && (int'(cfg_addr) < N_NODES)) begin
         cfg_d[int'(cfg_addr)*CFG_W +: CFG_W] = cfg_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_EVAL;
               ctr_d   = '0;
               word_d  = '0;
               onset_d = '0;
               inv_d   = out_inv;
            end
         end
         ST_EVAL: begin
            word_d[ctr_q[WB_W-1:0]] = f_w;
            onset_d = onset_q + {{N_IN{1'b0}}, f_w};
            ctr_d   = ctr_q + (N_IN+1)'(1);
            if (&ctr_q[WB_W-1:0]) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // ctr has already wrapped into its top bit after the final minterm
            if (tt_ready) begin
               state_d = ctr_q[N_IN] ? ST_DONE : ST_EVAL;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cfg_q   <= '0;
         ctr_q   <= '0;
         word_q  <= '0;
         onset_q <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         ctr_q   <= ctr_d;
         word_q  <= word_d;
         onset_q <= onset_d;
         inv_q   <= inv_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mig_tt_scanner.sv
`default_nettype none
// ============================================================================
// tb_mig_tt_scanner : directed self-checking bench for mig_tt_scanner.
// Revision          : 1.0
// ============================================================================
module tb_mig_tt_scanner;

   localparam int N_IN  = 7;
   localparam int TT_W  = 32;
   localparam int CFG_W = 15;
   localparam int LIMIT = 400;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             cfg_we   = 1'b0;
   logic [2:0]       cfg_addr = '0;
   logic [CFG_W-1:0] cfg_data = '0;
   logic             out_inv  = 1'b0;
   logic             start    = 1'b0;
   logic             tt_ready = 1'b0;
   logic             busy, done, tt_valid, tt_last;
   logic [TT_W-1:0]  tt_data;
   logic [N_IN:0]    onset_count;

   int checks   = 0;
   int failures = 0;

   logic [3:0][31:0] sw;
   logic [3:0]       sl;
   logic [N_IN:0]    s_onset;
   int               nw, ndone, done_cyc, first_valid, stall_err;
   logic             busy1, busy_end;

   always #5 clk = ~clk;

   mig_tt_scanner dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .out_inv     (out_inv),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .tt_valid    (tt_valid),
      .tt_ready    (tt_ready),
      .tt_data     (tt_data),
      .tt_last     (tt_last),
      .onset_count (onset_count)
   );

   function automatic logic [CFG_W-1:0] mk(input logic [4:0] c, input logic [4:0] b,
                                           input logic [4:0] a);
      return {c, b, a};
   endfunction

   task automatic write_cfg(input logic [2:0] a, input logic [CFG_W-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Runs one scan; cycle n is the cycle after the edge that sampled start (edge 0).
   // poke_cyc = 0 writes config alongside start; poke_cyc > 0 pokes cfg_we+start mid-scan.
   task automatic do_scan(input int stall, input int poke_cyc, input logic [2:0] pa,
                          input logic [CFG_W-1:0] pd);
      int          cyc, hold_cnt;
      logic [31:0] snap;
      logic        snap_l;
      sw = '0; sl = '0; nw = 0; ndone = 0; done_cyc = -1; first_valid = -1;
      stall_err = 0; busy1 = 1'b0; busy_end = 1'b1; hold_cnt = 0; snap = '0; snap_l = 1'b0;
      @(negedge clk);
      start = 1'b1;
      if (poke_cyc == 0) begin cfg_we = 1'b1; cfg_addr = pa; cfg_data = pd; end
      @(negedge clk);
      cyc = 1;
      forever begin
         if (cyc == poke_cyc) begin
            cfg_we = 1'b1; cfg_addr = pa; cfg_data = pd; start = 1'b1;
         end else begin
            cfg_we = 1'b0; start = 1'b0;
         end
         if (cyc == 1) busy1 = busy;
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = cyc; s_onset = onset_count; end
         end
         if (tt_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (hold_cnt < stall) begin
               if (hold_cnt == 0) begin snap = tt_data; snap_l = tt_last; end
               else if (tt_data !== snap || tt_last !== snap_l) stall_err++;
               hold_cnt++;
               tt_ready = 1'b0;
            end else begin
               if (hold_cnt > 0 && (tt_data !== snap || tt_last !== snap_l)) stall_err++;
               if (nw < 4) begin sw[nw] = tt_data; sl[nw] = tt_last; end
               nw++;
               hold_cnt = 0;
               tt_ready = 1'b1;
            end
         end else begin
            tt_ready = 1'b0;
         end
         if ((done_cyc >= 0 && cyc >= done_cyc + 4) || cyc >= LIMIT) break;
         @(negedge clk);
         cyc++;
      end
      busy_end = busy;
      cfg_we = 1'b0; start = 1'b0; tt_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (tt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tt_valid); end
      checks++; if (tt_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", tt_data); end
      checks++; if (tt_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", tt_last); end
      checks++; if (onset_count !== 8'd0) begin failures++; $display("FAIL reset_onset got=%0d exp=0", onset_count); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_maj3;
      out_inv = 1'b0;
      write_cfg(3'd5, mk(5'd3, 5'd2, 5'd1));
      do_scan(0, -1, 3'd0, '0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (sw[i] !== 32'hE8E8E8E8) begin failures++; $display("FAIL maj3_word%0d got=%h exp=e8e8e8e8", i, sw[i]); end
      end
      checks++; if (sl !== 4'b1000) begin failures++; $display("FAIL maj3_last got=%b exp=1000", sl); end
      checks++; if (nw !== 4) begin failures++; $display("FAIL maj3_nwords got=%0d exp=4", nw); end
      checks++; if (s_onset !== 8'd64) begin failures++; $display("FAIL maj3_onset got=%0d exp=64", s_onset); end
      checks++; if (first_valid !== 33) begin failures++; $display("FAIL maj3_first_valid got=%0d exp=33", first_valid); end
      checks++; if (done_cyc !== 133) begin failures++; $display("FAIL maj3_done_cycle got=%0d exp=133", done_cyc); end
      checks++; if (ndone !== 1) begin failures++; $display("FAIL maj3_done_pulses got=%0d exp=1", ndone); end
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL maj3_busy got=%b exp=1", busy1); end
      checks++; if (onset_count !== 8'd64) begin failures++; $display("FAIL maj3_onset_hold got=%0d exp=64", onset_count); end
   endtask

   task automatic test_const1;
      out_inv = 1'b0;
      write_cfg(3'd5, mk(5'h00, 5'h10, 5'h10));
      do_scan(0, -1, 3'd0, '0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (sw[i] !== 32'hFFFFFFFF) begin failures++; $display("FAIL const1_word%0d got=%h exp=ffffffff", i, sw[i]); end
      end
      checks++; if (s_onset !== 8'd128) begin failures++; $display("FAIL const1_onset got=%0d exp=128", s_onset); end
      out_inv = 1'b1;
      do_scan(0, -1, 3'd0, '0);
      out_inv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (sw[i] !== 32'h0) begin failures++; $display("FAIL inv_word%0d got=%h exp=00000000", i, sw[i]); end
      end
      checks++; if (s_onset !== 8'd0) begin failures++; $display("FAIL inv_onset got=%0d exp=0", s_onset); end
      checks++; if (sl !== 4'b1000) begin failures++; $display("FAIL inv_last got=%b exp=1000", sl); end
   endtask

   task automatic test_stall;
      write_cfg(3'd5, mk(5'd3, 5'd2, 5'd1));
      do_scan(5, -1, 3'd0, '0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (sw[i] !== 32'hE8E8E8E8) begin failures++; $display("FAIL stall_word%0d got=%h exp=e8e8e8e8", i, sw[i]); end
      end
      checks++; if (sl !== 4'b1000) begin failures++; $display("FAIL stall_last got=%b exp=1000", sl); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_stable got=%0d changes exp=0", stall_err); end
      checks++; if (done_cyc !== 153) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=153", done_cyc); end
      checks++; if (s_onset !== 8'd64) begin failures++; $display("FAIL stall_onset got=%0d exp=64", s_onset); end
   endtask

   task automatic test_forward;
      write_cfg(3'd0, mk(5'd11, 5'd11, 5'd11));
      do_scan(0, 0, 3'd5, mk(5'd1, 5'd1, 5'd8));
      for (int i = 0; i < 4; i++) begin
         checks++; if (sw[i] !== 32'hAAAAAAAA) begin failures++; $display("FAIL fwd_word%0d got=%h exp=aaaaaaaa", i, sw[i]); end
      end
      checks++; if (s_onset !== 8'd64) begin failures++; $display("FAIL fwd_onset got=%0d exp=64", s_onset); end
      checks++; if (done_cyc !== 133) begin failures++; $display("FAIL fwd_done_cycle got=%0d exp=133", done_cyc); end
   endtask

   task automatic test_reset_mid;
      write_cfg(3'd5, mk(5'd3, 5'd2, 5'd1));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; tt_ready = 1'b1;
      repeat (44) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (tt_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", tt_valid); end
      checks++; if (tt_data !== 32'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", tt_data); end
      checks++; if (tt_last !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_last_done got=%b%b exp=00", tt_last, done); end
      checks++; if (onset_count !== 8'd0) begin failures++; $display("FAIL mid_onset got=%0d exp=0", onset_count); end
      rst_n = 1'b1; tt_ready = 1'b0;
      do_scan(0, -1, 3'd0, '0);
      checks++; if (sw !== '0) begin failures++; $display("FAIL mid_cfg_cleared got=%h exp=0", sw); end
      checks++; if (s_onset !== 8'd0) begin failures++; $display("FAIL mid_cfg_onset got=%0d exp=0", s_onset); end
      write_cfg(3'd5, mk(5'd3, 5'd2, 5'd1));
      do_scan(0, -1, 3'd0, '0);
      checks++; if (sw !== {4{32'hE8E8E8E8}}) begin failures++; $display("FAIL mid_rescan got=%h exp=e8e8e8e8 x4", sw); end
      checks++; if (done_cyc !== 133) begin failures++; $display("FAIL mid_rescan_done got=%0d exp=133", done_cyc); end
   endtask

   task automatic test_busy_ignore;
      do_scan(0, 10, 3'd5, mk(5'h00, 5'h10, 5'h10));
      checks++; if (sw !== {4{32'hE8E8E8E8}}) begin failures++; $display("FAIL busy_words got=%h exp=e8e8e8e8 x4", sw); end
      checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_done_pulses got=%0d exp=1", ndone); end
      checks++; if (done_cyc !== 133) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=133", done_cyc); end
      checks++; if (busy_end !== 1'b0) begin failures++; $display("FAIL busy_after got=%b exp=0", busy_end); end
      do_scan(0, -1, 3'd0, '0);
      checks++; if (sw !== {4{32'hE8E8E8E8}}) begin failures++; $display("FAIL busy_cfg_kept got=%h exp=e8e8e8e8 x4", sw); end
      checks++; if (s_onset !== 8'd64) begin failures++; $display("FAIL busy_cfg_onset got=%0d exp=64", s_onset); end
   endtask

   initial begin
      test_reset;
      test_maj3;
      test_const1;
      test_stall;
      test_forward;
      test_reset_mid;
      test_busy_ignore;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
